fpcvt_seq_ctrl: RTL and testbench
=================================

// Module: fpcvt_seq_ctrl
// PURPOSE
//  Multi-cycle sequencer for the 12-bit two's-complement -> (S,E,F) floating-point conversion.
//  Accepts one sample per transaction over a valid/ready handshake.
//  Normalises the sample with a one-bit-per-cycle shift loop, then rounds.
//  Holds the result until the consumer takes it. Sits between the switch/ADC sample source
//  and the display/encoder logic, and replaces the single-cycle priority-encoder datapath.
// PARAMETERS
//  DW  12  input width, two's complement; constraint DW == (2**EW - 1) + FW + 1
//  EW   3  exponent width; EMAX = 2**EW - 1 = 7
//  FW   4  significand width
// PORTS
//  clk        in   1   single clock, rising edge
//  rst        in   1   asynchronous, active-high reset
//  in_valid   in   1   D is presented
//  in_ready   out  1   block can accept D (high only in IDLE)
//  D          in   DW  two's-complement sample
//  out_valid  out  1   S/E/F/sat hold a result
//  out_ready  in   1   consumer takes the result
//  S          out  1   sign bit
//  E          out  EW  exponent
//  F          out  FW  significand; value = F * 2**E
//  sat        out  1   result was clamped (-2048 input, or rounding overflow at EMAX)
// BEHAVIOUR
//  Reset (async): state=IDLE; in_ready=0 while rst is high, 1 once released; out_valid=0; S=0, E=0, F=0, sat=0.
//  States are IDLE -> NORM -> ROUND -> DONE -> IDLE.
//  IDLE: in_ready=1. On an edge with in_valid&in_ready, capture:
//   - sgn = D[DW-1]
//   - mag = |D|, DW-1 bits; D == 100..0 clamps to 2**(DW-1)-1 and sets clamp flag
//   - e = EMAX
//   Next state is NORM.
//  NORM: if mag[DW-2]==1 or e==0, go to ROUND. Otherwise mag<<=1 and e-=1, and stay in NORM.
//   n = number of shifts, 0..EMAX.
//  ROUND: f = mag[DW-2 -: FW]; r = mag[DW-2-FW].
//   - if r and f==all-ones and e==EMAX: F=all-ones, E=EMAX, sat=1
//   - elif r and f==all-ones: F=1000..0, E=e+1
//   - elif r: F=f+1, E=e
//   - else: F=f, E=e
//   sat also set if the clamp flag is set. S=sgn. Next state is DONE, out_valid=1.
//  DONE: out_valid=1 and S/E/F/sat are stable. On an edge with out_ready=1, go to IDLE and clear out_valid.
//   S/E/F/sat hold their last value until the next ROUND.
//  Latency: out_valid rises n+2 edges after the accept edge (min 2, max EMAX+2 = 9).
//   in_ready rises the edge after the out_ready transfer. No accept in the same cycle as a hand-off.
//  Zero input: n=EMAX, E=0, F=0, S=0. Negative zero cannot occur.
//  E==0 (|D| < 2**FW): F=|D| exactly; r is always 0.
//  in_valid low in IDLE: stay in IDLE. in_valid while not in IDLE: ignored; D is not sampled.
//  out_ready is ignored outside DONE.
//  rst asserted mid-operation: immediate return to IDLE with reset output values. The partial result is discarded.
// STRUCTURE
//  Shared package fpcvt_pkg:
//   - DW/EW/FW/EMAX localparams
//   - state encoding typedef {IDLE,NORM,ROUND,DONE} (2-bit)
//   - function fpcvt_round(f,r,e) -> {sat_ovf,E,F}
//  Sub-module fpcvt_norm_step: combinational one-step normaliser.
//   - in: mag, e
//   - out: mag_next, e_next, done
//   The FSM and registers stay in this module.
// TESTING
//  1 D=12'h599 (1433) -> S=0 E=7 F=4'b1011 sat=0; out_valid 2 cycles after accept.
//  2 D=12'hA72 (-1422) -> S=1 E=7 F=4'b1011 sat=0.
//  3 D=12'h800 (-2048) -> S=1 E=7 F=4'b1111 sat=1.
//  4 D=12'h55F -> E=7 F=4'b1011 (round up, no overflow).
//    D=12'h3E0 -> E=7 F=4'b1000 (mantissa overflow, exponent bump), out_valid 3 cycles after accept.
//  5 D=12'h00D -> E=0 F=4'b1101 after 9 cycles; D=0 -> S=0 E=0 F=0.
//  6 Handshake: hold out_ready=0 for 5 cycles -> outputs stable, in_ready=0 and new D ignored.
//    Assert rst during NORM -> out_valid=0, state IDLE, the next sample converts correctly.

Source files
------------

// File: rtl/fpcvt_pkg.sv
// Shared constants, FSM state encoding and the rounding step for the
// 12-bit two's-complement to (S,E,F) floating-point sequencer.
package fpcvt_pkg;
  localparam int DW   = 12;
  localparam int EW   = 3;
  localparam int FW   = 4;
  localparam int EMAX = 2**EW - 1;
  localparam int MW   = DW - 1;

  typedef enum logic [1:0] {IDLE, NORM, ROUND, DONE} state_t;

  typedef struct packed {
    logic          sat_ovf;
    logic [EW-1:0] e;
    logic [FW-1:0] f;
  } round_t;

  // Round-half-up on the guard bit; a carry out of the significand bumps the
  // exponent, unless the exponent is already at EMAX, where the result clamps.
  function automatic round_t fpcvt_round(input logic [FW-1:0] f, input logic r,
                                         input logic [EW-1:0] e);
    round_t res;
    res.sat_ovf = 1'b0;
    res.e       = e;
    res.f       = f;
    if (r && (&f) && (e == EW'(EMAX))) begin
      res.sat_ovf = 1'b1;
      res.f       = '1;
    end else if (r && (&f)) begin
      res.e = e + EW'(1);
      res.f = {1'b1, {(FW-1){1'b0}}};
    end else if (r) begin
      res.f = f + FW'(1);
    end
    return res;
  endfunction
endpackage

// File: rtl/fpcvt_norm_step.sv
// Combinational single-step normaliser: one left shift of the magnitude per call,
// finished once the top bit is set or the exponent has reached zero.
module fpcvt_norm_step
  import fpcvt_pkg::*;
(
  input  logic [MW-1:0] mag,
  input  logic [EW-1:0] e,
  output logic [MW-1:0] mag_next,
  output logic [EW-1:0] e_next,
  output logic          done
);
  assign done     = mag[MW-1] || (e == '0);
  assign mag_next = {mag[MW-2:0], 1'b0};
  assign e_next   = e - EW'(1);
endmodule

// File: rtl/fpcvt_seq_ctrl.sv
// Multi-cycle sequencer: accept a sample, normalise it one bit per cycle,
// round, and hold the (S,E,F,sat) result until the consumer takes it.
module fpcvt_seq_ctrl
  import fpcvt_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] D,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          S,
  output logic [EW-1:0] E,
  output logic [FW-1:0] F,
  output logic          sat
);
  state_t        state;
  logic [MW-1:0] mag;
  logic [EW-1:0] e;
  logic          sgn;
  logic          clamp;

  logic [MW-1:0] mag_next;
  logic [EW-1:0] e_next;
  logic          norm_done;
  logic          is_min;
  logic [MW-1:0] mag_in;
  round_t        rnd;

  fpcvt_norm_step u_norm (
    .mag      (mag),
    .e        (e),
    .mag_next (mag_next),
    .e_next   (e_next),
    .done     (norm_done)
  );

  // The most negative code has no positive counterpart in MW bits, so it clamps.
  assign is_min   = (D == {1'b1, {(DW-1){1'b0}}});
  assign mag_in   = D[DW-1] ? (~D[MW-1:0] + MW'(1)) : D[MW-1:0];
  assign rnd      = fpcvt_round(mag[MW-1 -: FW], mag[MW-1-FW], e);
  assign in_ready = (state == IDLE) && !rst;

  // Working registers: capture on accept, shift while normalising
  always_ff @(posedge clk) begin
    if (state == IDLE && in_valid) begin
      sgn   <= D[DW-1];
      clamp <= is_min;
      mag   <= is_min ? '1 : mag_in;
      e     <= EW'(EMAX);
    end else if (state == NORM && !norm_done) begin
      mag <= mag_next;
      e   <= e_next;
    end
  end

  // Control FSM and registered result
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      S         <= 1'b0;
      E         <= '0;
      F         <= '0;
      sat       <= 1'b0;
    end else begin
      case (state)
        IDLE:  if (in_valid) state <= NORM;
        NORM:  if (norm_done) state <= ROUND;
        ROUND: begin
          S         <= sgn;
          E         <= rnd.e;
          F         <= rnd.f;
          sat       <= rnd.sat_ovf | clamp;
          out_valid <= 1'b1;
          state     <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fpcvt_seq_ctrl.sv
// Directed bench for fpcvt_seq_ctrl: conversions with hand-computed results,
// latency, back-pressure and mid-conversion reset.
module tb_fpcvt_seq_ctrl;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [11:0] D = '0;
  logic        in_ready, out_valid, S, sat;
  logic [2:0]  E;
  logic [3:0]  F;

  int errors = 0;
  int checks = 0;
  int lat;

  always #5 clk = ~clk;

  fpcvt_seq_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .D         (D),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .S         (S),
    .E         (E),
    .F         (F),
    .sat       (sat)
  );

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present d at a negedge, accept on the next posedge, then count edges to out_valid.
  task automatic start(input logic [11:0] d, output int l);
    int guard = 0;
    while (!in_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    check("in_ready_idle", in_ready, 1);
    in_valid = 1'b1;
    D = d;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    D = 12'hABC;
    l = 0;
    while (!out_valid && l < 20) begin
      @(negedge clk);
      l++;
    end
  endtask

  task automatic result(input string tag, input int l, input int xl, input logic xs,
                        input logic [2:0] xe, input logic [3:0] xf, input logic xsat);
    check({tag, "_lat"}, l, xl);
    check({tag, "_S"}, S, xs);
    check({tag, "_E"}, E, xe);
    check({tag, "_F"}, F, xf);
    check({tag, "_sat"}, sat, xsat);
  endtask

  task automatic take(input string tag);
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, "_ovalid_clr"}, out_valid, 0);
    check({tag, "_iready_set"}, in_ready, 1);
  endtask

  task automatic run(input string tag, input logic [11:0] d, input int xl, input logic xs,
                     input logic [2:0] xe, input logic [3:0] xf, input logic xsat);
    start(d, lat);
    result(tag, lat, xl, xs, xe, xf, xsat);
    take(tag);
  endtask

  initial begin
    // Reset state
    @(negedge clk);
    @(negedge clk);
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_S", S, 0);
    check("rst_E", E, 0);
    check("rst_F", F, 0);
    check("rst_sat", sat, 0);
    rst = 1'b0;
    #1;
    check("rel_in_ready", in_ready, 1);
    @(negedge clk);

    // Basic conversions
    run("pos1433", 12'h599, 2, 1'b0, 3'd7, 4'b1011, 1'b0);
    run("neg1422", 12'hA72, 2, 1'b1, 3'd7, 4'b1011, 1'b0);
    run("min",     12'h800, 2, 1'b1, 3'd7, 4'b1111, 1'b1);
    run("rndup",   12'h55F, 2, 1'b0, 3'd7, 4'b1011, 1'b0);
    run("mantovf", 12'h3E0, 3, 1'b0, 3'd7, 4'b1000, 1'b0);
    run("small",   12'h00D, 9, 1'b0, 3'd0, 4'b1101, 1'b0);
    run("zero",    12'h000, 9, 1'b0, 3'd0, 4'b0000, 1'b0);
    run("neg1",    12'hFFF, 9, 1'b1, 3'd0, 4'b0001, 1'b0);
    run("max",     12'h7FF, 2, 1'b0, 3'd7, 4'b1111, 1'b1);
    run("mid64",   12'h040, 6, 1'b0, 3'd3, 4'b1000, 1'b0);

    // Back-pressure: result holds, new samples ignored
    start(12'h599, lat);
    result("hold", lat, 2, 1'b0, 3'd7, 4'b1011, 1'b0);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      D = 12'h800;
      @(negedge clk);
      check("hold_out_valid", out_valid, 1);
      check("hold_in_ready", in_ready, 0);
      check("hold_F", F, 4'b1011);
      check("hold_S", S, 0);
      check("hold_sat", sat, 0);
    end
    in_valid = 1'b0;
    take("hold");
    run("after_hold", 12'h55F, 2, 1'b0, 3'd7, 4'b1011, 1'b0);

    // Reset during normalisation
    in_valid = 1'b1;
    D = 12'h00D;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("midrst_busy", in_ready, 0);
    rst = 1'b1;
    #1;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_in_ready", in_ready, 0);
    check("midrst_E", E, 0);
    check("midrst_F", F, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("midrst_idle", in_ready, 1);
    @(negedge clk);
    run("post_rst", 12'h3E0, 3, 1'b0, 3'd7, 4'b1000, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
